cen_gen_multi: RTL



---
 rtl/cen_gen_multi_if.sv | 27 ++
 rtl/cen_gen_multi.sv | 127 ++++++++++++
 2 files changed

// File: rtl/cen_gen_multi_if.sv
// Configuration and strobe bundle of the multi-channel clock-enable generator.
// master = config source / strobe consumer, slave = generator.
interface cen_gen_multi_if #(
  parameter int NUM_CH = 3,
  parameter int ACC_W  = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic              cfg_sel;
  logic [ACC_W-1:0]  cfg_data;
  logic              cfg_apply;
  logic [NUM_CH-1:0] cen;
  logic [NUM_CH-1:0] cfg_err;
  logic              locked;

  modport master (
    output cfg_we, cfg_ch, cfg_sel, cfg_data, cfg_apply,
    input  cen, cfg_err, locked
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_sel, cfg_data, cfg_apply,
    output cen, cfg_err, locked
  );
endinterface

// File: rtl/cen_gen_multi.sv
// Runtime-reprogrammable NUM/DEN fractional clock-enable generator with
// shadow/active ratio sets and a PLL-style locked indication.
module cen_gen_multi #(
  parameter int                       NUM_CH      = 3,
  parameter int                       ACC_W       = 16,
  parameter int                       LOCK_CYCLES = 16,
  parameter logic [NUM_CH*ACC_W-1:0]  NUM_INIT    = {16'd1, 16'd1, 16'd1},
  parameter logic [NUM_CH*ACC_W-1:0]  DEN_INIT    = {16'd24, 16'd3, 16'd1}
) (
  input  logic            refclk,
  input  logic            rst,
  cen_gen_multi_if.slave  bus
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(NUM_CH);

  typedef enum logic {S_WAIT, S_RUN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   lock_cnt;
  logic               locked_r;
  logic [NUM_CH-1:0]  cen_r;
  logic [NUM_CH-1:0]  err_r;

  logic [ACC_W-1:0]   sh_num     [NUM_CH];
  logic [ACC_W-1:0]   sh_den     [NUM_CH];
  logic [ACC_W-1:0]   sh_num_nxt [NUM_CH];
  logic [ACC_W-1:0]   sh_den_nxt [NUM_CH];
  logic [ACC_W-1:0]   act_num    [NUM_CH];
  logic [ACC_W-1:0]   act_den    [NUM_CH];
  logic [ACC_W-1:0]   acc        [NUM_CH];
  logic [ACC_W:0]     sum        [NUM_CH];
  logic [NUM_CH-1:0]  ch_bad;
  logic               ch_ok;

  function automatic logic ratio_bad(input logic [ACC_W-1:0] n, input logic [ACC_W-1:0] d);
    return (n == '0) || (d == '0) || (n > d);
  endfunction

  assign ch_ok = ({1'b0, bus.cfg_ch} < CH_LIMIT);

  // Shadow next-state is shared by the shadow update and apply, so a write in
  // the same cycle as cfg_apply lands in the applied set.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sh_num_nxt[i] = sh_num[i];
      sh_den_nxt[i] = sh_den[i];
      if (bus.cfg_we && ch_ok && (bus.cfg_ch == CH_W'(i))) begin
        if (bus.cfg_sel) sh_den_nxt[i] = bus.cfg_data;
        else             sh_num_nxt[i] = bus.cfg_data;
      end
      ch_bad[i] = ratio_bad(act_num[i], act_den[i]);
      sum[i]    = {1'b0, acc[i]} + {1'b0, act_num[i]};
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        sh_num[i]  <= NUM_INIT[i*ACC_W +: ACC_W];
        sh_den[i]  <= DEN_INIT[i*ACC_W +: ACC_W];
        act_num[i] <= NUM_INIT[i*ACC_W +: ACC_W];
        act_den[i] <= DEN_INIT[i*ACC_W +: ACC_W];
        acc[i]     <= '0;
        err_r[i]   <= ratio_bad(NUM_INIT[i*ACC_W +: ACC_W], DEN_INIT[i*ACC_W +: ACC_W]);
      end
      cen_r    <= '0;
      locked_r <= 1'b0;
      lock_cnt <= '0;
      state    <= S_WAIT;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        sh_num[i] <= sh_num_nxt[i];
        sh_den[i] <= sh_den_nxt[i];
      end
      err_r <= ch_bad;

      if (bus.cfg_apply) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          act_num[i] <= sh_num_nxt[i];
          act_den[i] <= sh_den_nxt[i];
          acc[i]     <= '0;
        end
        cen_r    <= '0;
        locked_r <= 1'b0;
        lock_cnt <= '0;
        state    <= S_WAIT;
      end else begin
        case (state)
          S_WAIT: begin
            for (int unsigned i = 0; i < NUM_CH; i++) acc[i] <= '0;
            cen_r <= '0;
            if (lock_cnt == CNT_LAST) begin
              state    <= S_RUN;
              locked_r <= 1'b1;
            end else begin
              lock_cnt <= lock_cnt + 1'b1;
            end
          end
          S_RUN: begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
              if (ch_bad[i]) begin
                acc[i]   <= '0;
                cen_r[i] <= 1'b0;
              end else if (sum[i] >= {1'b0, act_den[i]}) begin
                acc[i]   <= ACC_W'(sum[i] - {1'b0, act_den[i]});
                cen_r[i] <= 1'b1;
              end else begin
                acc[i]   <= ACC_W'(sum[i]);
                cen_r[i] <= 1'b0;
              end
            end
          end
          default: state <= S_WAIT;
        endcase
      end
    end
  end

  assign bus.cen     = cen_r;
  assign bus.cfg_err = err_r;
  assign bus.locked  = locked_r;

endmodule
